mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Initiator side of the mole/hammer exchange.
- Picks a pseudo-random mole position (0..17) and presents it for a difficulty-dependent dwell time.
- Accepts the hammer's one-cycle `hit` response, counts hits and misses, and ends the round after a fixed number of moles.
- Drives the mole position consumed by the hammer and the one-hot LED bar shown to the player.

Parameters:
- CLKS_PER_MS, 50000, clock cycles per millisecond tick (benches use 4)
- NUM_HOLES, 18, number of mole positions and LED width
- ROUND_MOLES, 20, moles presented per round
- DWELL_EASY_MS, 2000, mole lifetime at difficulty 0
- DWELL_MED_MS, 1000, mole lifetime at difficulty 1
- DWELL_HARD_MS, 600, mole lifetime at difficulty 2
- GAP_MS, 250, blank time between moles
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse; begins a round from IDLE or DONE
- abort, in, 1, level; returns to IDLE from any active state
- difficulty, in, 4, 0 = easy, 1 = medium, 2 = hard; any other value = easy
- hit, in, 1, one-cycle pulse from the hammer
- mole_position, out, 5, current mole index; holds last value when inactive
- mole_active, out, 1, high while a mole is shown
- mole_leds, out, NUM_HOLES, one-hot at mole_position when active, else 0
- new_mole, out, 1, one-cycle pulse on entry to SHOW
- hits, out, 8, hits this round, saturates at 255
- misses, out, 8, timeouts this round, saturates at 255
- moles_shown, out, 8, moles presented this round
- round_done, out, 1, high in DONE

Behaviour:
- Reset: state IDLE, all outputs 0, LFSR = LFSR_SEED, prev_pos = 31 (none), ms prescaler and ms counter 0.
- Timebase: prescaler counts 0..CLKS_PER_MS-1 and emits a one-cycle ms_tick at the wrap.
  - Prescaler and ms counter clear on every state entry.
  - The ms counter increments on ms_tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in PICK only.
- States and transitions:
  - IDLE: outputs inactive. start → GAP, clearing hits, misses, moles_shown and round_done.
  - GAP: mole_active = 0. When the ms counter reaches GAP_MS → PICK.
  - PICK: candidate = lfsr[4:0].
    - Accept only if candidate < NUM_HOLES and candidate != prev_pos; otherwise stay in PICK (LFSR advances).
    - On accept: latch mole_position, set prev_pos, latch the dwell value from difficulty, increment moles_shown → SHOW.
    - PICK lasts at most 64 cycles (guaranteed by the maximal-length LFSR).
  - SHOW: mole_active = 1; new_mole pulses in the first SHOW cycle. mole_active and mole_leds are registered together.
    - hit → hits+1.
    - Ms counter reaching the latched dwell without a hit → misses+1.
    - Either way, go to DONE if moles_shown == ROUND_MOLES, else GAP.
    - mole_active falls the cycle after the terminating event.
  - DONE: round_done = 1, counters held. start → GAP, same clears as from IDLE.
- Boundary conditions:
  - hit and timeout in the same cycle: counts as a hit only.
  - hit outside SHOW: ignored, no counter change.
  - Multiple hit pulses in one mole: only the first counts, because the state leaves SHOW.
  - Difficulty change mid-mole: no effect until the next PICK.
  - abort high in GAP/PICK/SHOW: → IDLE next cycle, mole_active = 0, counters preserved. abort is ignored in IDLE/DONE.
  - abort and start asserted together: abort wins.
  - start in GAP/PICK/SHOW: ignored.
  - Counter saturation: hits and misses hold at 255.
  - rst_n asserted mid-round: immediate return to reset values, no completion of the pending mole.

Decomposition:
- Package mole_pkg holds:
  - state encoding (IDLE, GAP, PICK, SHOW, DONE)
  - difficulty codes (DIFF_EASY = 0, DIFF_MED = 1, DIFF_HARD = 2)
  - LFSR tap mask
  - NO_POS = 31
- Sub-module mole_lfsr: 16-bit LFSR with seed parameter, advance input and value output.

Test Plan (all with CLKS_PER_MS = 4):
- Reset, then start with difficulty = 0 and no hits → new_mole after 250 ms (1000 cycles plus one PICK cycle); mole_active high for exactly 2000 ms; misses = 1.
- difficulty = 2, pulse hit 10 cycles after new_mole → hits = 1, mole_active low on the next cycle, GAP begins, misses = 0.
- Full round of 20 moles, hit on even-numbered moles → round_done = 1, hits = 10, misses = 10, moles_shown = 20; a further start clears all counters to 0.
- hit and the timeout tick in the same cycle → hits + 1, misses unchanged; hit pulsed during GAP → no counter change.
- abort during SHOW → IDLE next cycle, mole_leds = 0, counters retained; rst_n low mid-SHOW → all outputs 0 asynchronously.
- Across 200 moles: mole_position always < 18, never equal to the previous mole, mole_leds always one-hot matching mole_position.

Source files
------------

// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared encodings for the mole scheduler
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_PICK = 3'd2,
        ST_SHOW = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [3:0] DIFF_EASY = 4'd0;
    localparam logic [3:0] DIFF_MED  = 4'd1;
    localparam logic [3:0] DIFF_HARD = 4'd2;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // prev_pos value meaning "no mole shown yet"
    localparam logic [4:0] NO_POS = 5'd31;

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - 16-bit Fibonacci LFSR, advances on request
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] value
);

    // shift left, feeding back the xor of the tapped bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - mole presentation, timing and hit/miss scoring
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          CLKS_PER_MS   = 50000,
    parameter int          NUM_HOLES     = 18,
    parameter int          ROUND_MOLES   = 20,
    parameter int          DWELL_EASY_MS = 2000,
    parameter int          DWELL_MED_MS  = 1000,
    parameter int          DWELL_HARD_MS = 600,
    parameter int          GAP_MS        = 250,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3:0]           difficulty,
    input  logic                 hit,
    output logic [4:0]           mole_position,
    output logic                 mole_active,
    output logic [NUM_HOLES-1:0] mole_leds,
    output logic                 new_mole,
    output logic [7:0]           hits,
    output logic [7:0]           misses,
    output logic [7:0]           moles_shown,
    output logic                 round_done
);

    localparam logic [15:0]          PRESC_MAX = 16'(CLKS_PER_MS - 1);
    localparam logic [15:0]          GAP_LAST  = 16'(GAP_MS - 1);
    localparam logic [5:0]           HOLES     = 6'(NUM_HOLES);
    localparam logic [7:0]           LAST_MOLE = 8'(ROUND_MOLES);
    localparam logic [NUM_HOLES-1:0] LED_ONE   = NUM_HOLES'(1);

    state_t      state;
    state_t      state_next;
    logic [15:0] presc;
    logic [15:0] ms_cnt;
    logic [15:0] dwell_ms;
    logic [15:0] dwell_sel;
    logic [4:0]  prev_pos;
    logic [15:0] lfsr_value;
    logic [4:0]  cand;
    logic        accept;
    logic        ms_tick;
    logic        gap_done;
    logic        dwell_done;
    logic        unused_lfsr_bits;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (state == ST_PICK),
        .value   (lfsr_value)
    );

    assign cand             = lfsr_value[4:0];
    assign unused_lfsr_bits = ^lfsr_value[15:5];
    assign accept           = ({1'b0, cand} < HOLES) && (cand != prev_pos);
    assign ms_tick          = (presc == PRESC_MAX);
    // a limit is "reached" on the tick that would carry the counter onto it
    assign gap_done         = ms_tick && (ms_cnt == GAP_LAST);
    assign dwell_done       = ms_tick && (ms_cnt == dwell_ms - 16'd1);

    // dwell lookup; unknown difficulty codes fall back to easy
    always_comb begin
        dwell_sel = 16'(DWELL_EASY_MS);
        case (difficulty)
            DIFF_MED:  dwell_sel = 16'(DWELL_MED_MS);
            DIFF_HARD: dwell_sel = 16'(DWELL_HARD_MS);
            default:   dwell_sel = 16'(DWELL_EASY_MS);
        endcase
    end

    // next-state decision; abort beats every other request in active states
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (abort)         state_next = ST_IDLE;
                else if (gap_done) state_next = ST_PICK;
            end
            ST_PICK: begin
                if (abort)       state_next = ST_IDLE;
                else if (accept) state_next = ST_SHOW;
            end
            ST_SHOW: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (hit || dwell_done) begin
                    state_next = (moles_shown == LAST_MOLE) ? ST_DONE : ST_GAP;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // ms timebase, restarted on every state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (state_next != state) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (ms_tick) begin
            presc  <= '0;
            ms_cnt <= ms_cnt + 16'd1;
        end else begin
            presc  <= presc + 16'd1;
        end
    end

    // registered outputs, scoring and mole latching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mole_position <= '0;
            mole_active   <= 1'b0;
            mole_leds     <= '0;
            new_mole      <= 1'b0;
            hits          <= '0;
            misses        <= '0;
            moles_shown   <= '0;
            round_done    <= 1'b0;
            prev_pos      <= NO_POS;
            dwell_ms      <= '0;
        end else begin
            new_mole   <= 1'b0;
            round_done <= (state_next == ST_DONE);
            if ((state == ST_IDLE || state == ST_DONE) && state_next == ST_GAP) begin
                hits        <= '0;
                misses      <= '0;
                moles_shown <= '0;
            end
            if (state == ST_PICK && state_next == ST_SHOW) begin
                mole_position <= cand;
                prev_pos      <= cand;
                dwell_ms      <= dwell_sel;
                moles_shown   <= moles_shown + 8'd1;
                new_mole      <= 1'b1;
                mole_active   <= 1'b1;
                mole_leds     <= LED_ONE << cand;
            end
            if (state == ST_SHOW && state_next != ST_SHOW) begin
                mole_active <= 1'b0;
                mole_leds   <= '0;
                if (!abort) begin
                    if (hit) begin
                        if (hits != 8'hFF) hits <= hits + 8'd1;
                    end else if (misses != 8'hFF) begin
                        misses <= misses + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - self-checking bench for mole_scheduler
module tb_mole_scheduler;

    localparam int C = 4;
    localparam int F_GAP = 3, F_EASY = 5, F_MED = 4, F_HARD = 3;
    localparam int M_IDLE = 0, M_GAP = 1, M_PICK = 2, M_SHOW = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic        start [2];
    logic        abort [2];
    logic        hit [2];
    logic [3:0]  difficulty [2];
    logic [4:0]  mole_position [2];
    logic        mole_active [2];
    logic [17:0] mole_leds [2];
    logic        new_mole [2];
    logic [7:0]  hits [2];
    logic [7:0]  misses [2];
    logic [7:0]  moles_shown [2];
    logic        round_done [2];

    int errors = 0;
    int checks = 0;

    // reference model: per-instance mode, remaining-cycle countdown and score
    int          m_mode [2];
    int          m_left [2];
    logic [15:0] m_lfsr [2];
    int          m_prev [2];
    int          m_old_prev [2];
    int          m_pos [2];
    int          m_hits [2];
    int          m_miss [2];
    int          m_shown [2];
    bit          m_active [2];
    bit          m_new [2];

    always #5 clk = ~clk;

    mole_scheduler #(.CLKS_PER_MS(C)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .difficulty(difficulty[0]), .hit(hit[0]), .mole_position(mole_position[0]),
        .mole_active(mole_active[0]), .mole_leds(mole_leds[0]), .new_mole(new_mole[0]),
        .hits(hits[0]), .misses(misses[0]), .moles_shown(moles_shown[0]),
        .round_done(round_done[0])
    );

    mole_scheduler #(.CLKS_PER_MS(C), .GAP_MS(F_GAP), .DWELL_EASY_MS(F_EASY),
                     .DWELL_MED_MS(F_MED), .DWELL_HARD_MS(F_HARD)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .difficulty(difficulty[1]), .hit(hit[1]), .mole_position(mole_position[1]),
        .mole_active(mole_active[1]), .mole_leds(mole_leds[1]), .new_mole(new_mole[1]),
        .hits(hits[1]), .misses(misses[1]), .moles_shown(moles_shown[1]),
        .round_done(round_done[1])
    );

    function automatic int gap_cycles(int k);
        return (k == 0 ? 250 : F_GAP) * C;
    endfunction

    function automatic int dwell_cycles(int k, logic [3:0] d);
        int ms;
        if (d == 4'd1)      ms = (k == 0) ? 1000 : F_MED;
        else if (d == 4'd2) ms = (k == 0) ? 600 : F_HARD;
        else                ms = (k == 0) ? 2000 : F_EASY;
        return ms * C;
    endfunction

    function automatic logic [15:0] lfsr_adv(logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_left[k] = 0; m_lfsr[k] = 16'hACE1;
            m_prev[k] = 31; m_old_prev[k] = 31; m_pos[k] = 0;
            m_hits[k] = 0; m_miss[k] = 0; m_shown[k] = 0;
            m_active[k] = 0; m_new[k] = 0;
        end
    endfunction

    function automatic void model_step(int k);
        int  cand;
        bit  ended;
        m_new[k] = 0;
        ended = 0;
        if (m_mode[k] == M_IDLE || m_mode[k] == M_DONE) begin
            if (start[k] && !abort[k]) begin
                m_mode[k] = M_GAP; m_left[k] = gap_cycles(k);
                m_hits[k] = 0; m_miss[k] = 0; m_shown[k] = 0;
            end
        end else if (abort[k]) begin
            if (m_mode[k] == M_PICK) m_lfsr[k] = lfsr_adv(m_lfsr[k]);
            m_mode[k] = M_IDLE; m_active[k] = 0;
        end else if (m_mode[k] == M_GAP) begin
            m_left[k]--;
            if (m_left[k] == 0) m_mode[k] = M_PICK;
        end else if (m_mode[k] == M_PICK) begin
            cand = int'(m_lfsr[k][4:0]);
            m_lfsr[k] = lfsr_adv(m_lfsr[k]);
            if (cand < 18 && cand != m_prev[k]) begin
                m_old_prev[k] = m_prev[k];
                m_pos[k] = cand; m_prev[k] = cand; m_shown[k]++;
                m_mode[k] = M_SHOW; m_left[k] = dwell_cycles(k, difficulty[k]);
                m_active[k] = 1; m_new[k] = 1;
            end
        end else begin
            if (hit[k]) begin
                if (m_hits[k] < 255) m_hits[k]++;
                ended = 1;
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    if (m_miss[k] < 255) m_miss[k]++;
                    ended = 1;
                end
            end
            if (ended) begin
                m_active[k] = 0;
                m_mode[k] = (m_shown[k] == 20) ? M_DONE : M_GAP;
                m_left[k] = gap_cycles(k);
            end
        end
    endfunction

    function automatic void check_model(int k);
        logic [17:0] exp_leds;
        exp_leds = m_active[k] ? (18'd1 << m_pos[k]) : 18'd0;
        checks++;
        if (mole_position[k] !== 5'(m_pos[k]) || mole_active[k] !== m_active[k] ||
            mole_leds[k] !== exp_leds || new_mole[k] !== m_new[k] ||
            hits[k] !== 8'(m_hits[k]) || misses[k] !== 8'(m_miss[k]) ||
            moles_shown[k] !== 8'(m_shown[k]) || round_done[k] !== (m_mode[k] == M_DONE)) begin
            errors++;
            $display("FAIL model[%0d] t=%0t got pos=%0d act=%b leds=%h new=%b h=%0d m=%0d n=%0d done=%b want pos=%0d act=%b leds=%h new=%b h=%0d m=%0d n=%0d done=%b",
                     k, $time, mole_position[k], mole_active[k], mole_leds[k], new_mole[k],
                     hits[k], misses[k], moles_shown[k], round_done[k], m_pos[k], m_active[k],
                     exp_leds, m_new[k], m_hits[k], m_miss[k], m_shown[k], m_mode[k] == M_DONE);
        end
    endfunction

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        check_model(0);
        check_model(1);
    endtask

    task automatic wait_new_mole(int k, int budget);
        int n = 0;
        while (!new_mole[k] && n < budget) begin
            cycle();
            n++;
        end
        check("new_mole_within_budget", int'(new_mole[k]), 1);
    endtask

    task automatic pulse_start(int k);
        start[k] = 1'b1; cycle(); start[k] = 1'b0;
    endtask

    typedef struct {
        logic [3:0] diff;
        logic [3:0] diff_mid;
        int         exp_cycles;
    } dwell_vec_t;

    initial begin
        dwell_vec_t vecs [5];
        int n;
        int seen;
        int cyc;

        vecs[0] = '{4'd0, 4'd2, F_EASY * C};
        vecs[1] = '{4'd1, 4'd0, F_MED * C};
        vecs[2] = '{4'd2, 4'd0, F_HARD * C};
        vecs[3] = '{4'd3, 4'd1, F_EASY * C};
        vecs[4] = '{4'd15, 4'd2, F_EASY * C};

        for (int k = 0; k < 2; k++) begin
            start[k] = 0; abort[k] = 0; hit[k] = 0; difficulty[k] = 0;
        end
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_active", int'(mole_active[0]), 0);
        check("reset_leds", int'(mole_leds[0]), 0);
        check("reset_pos", int'(mole_position[0]), 0);
        check("reset_counts", int'({hits[0], misses[0], moles_shown[0]}), 0);
        check("reset_done", int'(round_done[0]), 0);
        rst_n = 1'b1;

        // easy mole, never hit: 250 ms gap + one PICK cycle, 2000 ms shown
        difficulty[0] = 4'd0;
        pulse_start(0);
        n = 0;
        while (!new_mole[0] && n < 2000) begin cycle(); n++; end
        check("gap_latency", n, 250 * C + 1);
        check("first_pos_from_seed", int'(mole_position[0]), 1);
        n = 0;
        while (mole_active[0] && n < 9000) begin n++; cycle(); end
        check("easy_dwell", n, 2000 * C);
        check("easy_miss", int'(misses[0]), 1);
        abort[0] = 1'b1; cycle(); abort[0] = 1'b0;
        check("abort_gap_keeps_miss", int'(misses[0]), 1);

        // hard mole hit 10 cycles after new_mole
        difficulty[0] = 4'd2;
        pulse_start(0);
        wait_new_mole(0, 1100);
        repeat (10) cycle();
        hit[0] = 1'b1; cycle(); hit[0] = 1'b0;
        check("hard_hit", int'(hits[0]), 1);
        check("hard_hit_active_low", int'(mole_active[0]), 0);
        check("hard_hit_no_miss", int'(misses[0]), 0);

        // hit in GAP is ignored
        repeat (5) cycle();
        hit[0] = 1'b1; cycle(); hit[0] = 1'b0;
        check("gap_hit_ignored", int'(hits[0]), 1);

        // hit on the exact timeout cycle counts only as a hit
        wait_new_mole(0, 1100);
        repeat (600 * C - 1) cycle();
        hit[0] = 1'b1; cycle(); hit[0] = 1'b0;
        check("tie_hit", int'(hits[0]), 2);
        check("tie_no_miss", int'(misses[0]), 0);
        check("tie_active_low", int'(mole_active[0]), 0);

        // abort during SHOW
        wait_new_mole(0, 1100);
        repeat (5) cycle();
        abort[0] = 1'b1; cycle(); abort[0] = 1'b0;
        check("abort_show_active", int'(mole_active[0]), 0);
        check("abort_show_leds", int'(mole_leds[0]), 0);
        check("abort_show_hits", int'(hits[0]), 2);
        check("abort_show_shown", int'(moles_shown[0]), 3);

        // start together with abort in IDLE: abort wins, round does not begin
        start[0] = 1'b1; abort[0] = 1'b1; cycle(); start[0] = 1'b0; abort[0] = 1'b0;
        repeat (1100) cycle();
        check("start_abort_idle", int'(moles_shown[0]), 3);

        // asynchronous reset in the middle of SHOW
        pulse_start(0);
        wait_new_mole(0, 1100);
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        check("rst_active", int'(mole_active[0]), 0);
        check("rst_leds", int'(mole_leds[0]), 0);
        check("rst_counts", int'({hits[0], misses[0], moles_shown[0]}), 0);
        check("rst_pos", int'(mole_position[0]), 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();

        // full hard round: hit even moles, let odd ones time out
        difficulty[0] = 4'd2;
        pulse_start(0);
        for (int m = 1; m <= 20; m++) begin
            wait_new_mole(0, 1200);
            if (m % 2 == 0) begin
                repeat (10) cycle();
                hit[0] = 1'b1; cycle(); hit[0] = 1'b0;
            end else begin
                n = 0;
                while (mole_active[0] && n < 2500) begin cycle(); n++; end
            end
        end
        check("round_done", int'(round_done[0]), 1);
        check("round_hits", int'(hits[0]), 10);
        check("round_misses", int'(misses[0]), 10);
        check("round_shown", int'(moles_shown[0]), 20);
        abort[0] = 1'b1; start[0] = 1'b1; cycle(); abort[0] = 1'b0; start[0] = 1'b0;
        check("done_abort_start", int'(round_done[0]), 1);
        pulse_start(0);
        check("restart_clears", int'({hits[0], misses[0], moles_shown[0]}), 0);
        check("restart_done_low", int'(round_done[0]), 0);
        abort[0] = 1'b1; cycle(); abort[0] = 1'b0;

        // dwell per difficulty, with a mid-mole difficulty change
        for (int i = 0; i < 5; i++) begin
            difficulty[1] = vecs[i].diff;
            pulse_start(1);
            wait_new_mole(1, 200);
            difficulty[1] = vecs[i].diff_mid;
            n = 0;
            while (mole_active[1] && n < 100) begin n++; cycle(); end
            check($sformatf("dwell_diff%0d", vecs[i].diff), n, vecs[i].exp_cycles);
            abort[1] = 1'b1; cycle(); abort[1] = 1'b0;
        end

        // random traffic over 200 moles
        seen = 0;
        cyc = 0;
        while (seen < 200 && cyc < 30000) begin
            start[1] = ($urandom_range(7) == 0);
            abort[1] = ($urandom_range(255) == 0);
            hit[1]   = ($urandom_range(23) == 0);
            if ($urandom_range(31) == 0) difficulty[1] = 4'($urandom_range(15));
            cycle();
            cyc++;
            if (new_mole[1]) begin
                seen++;
                check("rand_pos_range", int'(mole_position[1] < 5'd18), 1);
                check("rand_no_repeat", int'(mole_position[1]) == m_old_prev[1] ? 1 : 0, 0);
                check("rand_leds_onehot", int'(mole_leds[1] == (18'd1 << mole_position[1])), 1);
            end
        end
        start[1] = 0; abort[1] = 0; hit[1] = 0;
        check("rand_moles_seen", seen, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
